// File: rtl/fir_stream_driver.sv
// fir_stream_driver: host sample FIFO + shadow coefficient bank that
// sequences x_n / s_axis_fir_tvalid / s_set_coeffs into the FIR core.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid    host sample stream, in_ready = FIFO not full
//   cfg_we/addr/data    shadow coefficient write port
//   cfg_commit          request to load the shadow bank into the filter
//   x_n, s_axis_fir_tvalid, s_set_coeffs   registered filter drive
//   busy                setup/load/gap in progress or commit pending
//   fifo_level          sample FIFO occupancy
//
// Option macro FIR_DRV_ZEROFILL_EN: when defined, an empty FIFO in
// STREAM drives tvalid=1 with x_n=0 and STREAM is left only on a commit.
module fir_stream_driver #(
    parameter int X_N_SIZE     = 8,
    parameter int TAP_SIZE     = 6,
    parameter int NBR_OF_TAPS  = 3,
    parameter int FIFO_DEPTH   = 8,
    parameter int SETUP_CYCLES = 4,
    localparam int AW = $clog2(NBR_OF_TAPS),
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int LW = PW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [X_N_SIZE-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [TAP_SIZE-1:0] cfg_data,
    input  logic                cfg_commit,
    output logic [X_N_SIZE-1:0] x_n,
    output logic                s_axis_fir_tvalid,
    output logic                s_set_coeffs,
    output logic                busy,
    output logic [LW-1:0]       fifo_level
);

    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_SETUP,
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_STREAM
    } state_t;

    state_t state;

    logic [SW-1:0] setup_cnt;
    logic [AW-1:0] load_k;
    logic          commit_pend;

    logic [TAP_SIZE-1:0] coef [NBR_OF_TAPS];
    logic [TAP_SIZE-1:0] snap [NBR_OF_TAPS];
    logic [TAP_SIZE-1:0] load_val;

    logic [X_N_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [LW-1:0]       count;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic load_go;

    assign fifo_full  = (count == LW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign in_ready   = !fifo_full;
    assign fifo_level = count;
    assign push       = in_valid && in_ready;
    assign pop        = (state == ST_STREAM) && !fifo_empty;

    // LOAD is entered from IDLE or STREAM whenever a commit is pending
    assign load_go = commit_pend &&
                     ((state == ST_IDLE) || (state == ST_STREAM));

    assign busy = (state == ST_SETUP) || (state == ST_LOAD) ||
                  (state == ST_GAP) || commit_pend;

    // Cycle k of LOAD drives snap[N-1-k], leaving coef[0] in tap 0
    always_comb begin
        load_val = '0;
        for (int i = 0; i < NBR_OF_TAPS; i++) begin
            if (load_k == AW'(NBR_OF_TAPS - 1 - i)) begin
                load_val = snap[i];
            end
        end
    end

    // Shadow bank, snapshot and commit request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBR_OF_TAPS; i++) begin
                coef[i] <= '0;
                snap[i] <= '0;
            end
            commit_pend <= 1'b0;
        end else begin
            // out-of-range addresses match no entry and are dropped
            for (int i = 0; i < NBR_OF_TAPS; i++) begin
                if (cfg_we && (cfg_addr == AW'(i))) begin
                    coef[i] <= cfg_data;
                end
            end
            if (load_go) begin
                for (int i = 0; i < NBR_OF_TAPS; i++) begin
                    snap[i] <= coef[i];
                end
            end
            // a commit in the same cycle as LOAD entry is kept
            if (cfg_commit) begin
                commit_pend <= 1'b1;
            end else if (load_go) begin
                commit_pend <= 1'b0;
            end
        end
    end

    // Sample FIFO storage needs no reset: occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer with registered filter drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_SETUP;
            setup_cnt         <= '0;
            load_k            <= '0;
            x_n               <= '0;
            s_axis_fir_tvalid <= 1'b0;
            s_set_coeffs      <= 1'b0;
        end else begin
            x_n               <= '0;
            s_axis_fir_tvalid <= 1'b0;
            s_set_coeffs      <= 1'b0;
            unique case (state)
                ST_SETUP: begin
                    if (setup_cnt == SW'(SETUP_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        setup_cnt <= setup_cnt + SW'(1);
                    end
                end
                ST_IDLE: begin
                    if (commit_pend) begin
                        state  <= ST_LOAD;
                        load_k <= '0;
                    end else if (!fifo_empty) begin
                        state <= ST_STREAM;
                    end
                end
                ST_LOAD: begin
                    s_set_coeffs <= 1'b1;
                    x_n          <= X_N_SIZE'($signed(load_val));
                    if (load_k == AW'(NBR_OF_TAPS - 1)) begin
                        state <= ST_GAP;
                    end else begin
                        load_k <= load_k + AW'(1);
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                ST_STREAM: begin
                    if (pop) begin
                        x_n               <= mem[rd_ptr];
                        s_axis_fir_tvalid <= 1'b1;
                    end else begin
`ifdef FIR_DRV_ZEROFILL_EN
                        s_axis_fir_tvalid <= 1'b1;
`else
                        s_axis_fir_tvalid <= 1'b0;
`endif
                    end
                    if (commit_pend) begin
                        state  <= ST_LOAD;
                        load_k <= '0;
`ifndef FIR_DRV_ZEROFILL_EN
                    end else if (fifo_empty && !push) begin
                        state <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    state <= ST_SETUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stream_driver.sv
// tb_fir_stream_driver: scoreboard bench for fir_stream_driver.
// Reference model: ordered sample queue and per-commit tap sequences.
module tb_fir_stream_driver;

    localparam int NT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [5:0] cfg_data = '0;
    logic       cfg_commit = 1'b0;
    logic [7:0] x_n;
    logic       tvalid;
    logic       set_c;
    logic       busy;
    logic [3:0] fifo_level;

    fir_stream_driver dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .cfg_we            (cfg_we),
        .cfg_addr          (cfg_addr),
        .cfg_data          (cfg_data),
        .cfg_commit        (cfg_commit),
        .x_n               (x_n),
        .s_axis_fir_tvalid (tvalid),
        .s_set_coeffs      (set_c),
        .busy              (busy),
        .fifo_level        (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         acc;
    } samp_t;

    samp_t      samp_q [$];
    logic [7:0] load_q [$];
    logic [5:0] coef_m [4];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int run = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] sx(input logic [5:0] c);
        int v;
        v = (c >= 6'd32) ? int'(c) - 64 : int'(c);
        return 8'(v);
    endfunction

    // Monitor: every filter-side beat is checked against the model
    always @(negedge clk) begin
        samp_t s;
        if (!rst_n) begin
            run = 0;
        end else begin
            if (tvalid && set_c) chk("strobe_overlap", 1, 0);
            if (set_c) begin
                if (load_q.size() == 0) chk("unexpected_load", x_n, 9'h100);
                else chk("load_value", x_n, load_q.pop_front());
                run++;
            end else if (run > 0) begin
                chk("load_len", run, NT);
                chk("gap_tvalid", tvalid, 0);
                run = 0;
            end
            if (tvalid) begin
                if (samp_q.size() > 0 && samp_q[0].acc < cyc) begin
                    s = samp_q.pop_front();
                    chk("sample", x_n, s.d);
                end else begin
`ifdef FIR_DRV_ZEROFILL_EN
                    chk("zero_fill", x_n, 0);
`else
                    chk("spurious_tvalid", 1, 0);
`endif
                end
            end
        end
    end

    task automatic cyc_start();
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, output bit ok);
        in_valid = 1'b1;
        in_data  = d;
        ok = in_ready;
        if (ok) samp_q.push_back('{d, cyc + 1});
    endtask

    task automatic write(input int a, input logic [5:0] d);
        cfg_we   = 1'b1;
        cfg_addr = 2'(a);
        cfg_data = d;
        if (a < NT) coef_m[a] = d;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        for (int i = NT - 1; i >= 0; i--) load_q.push_back(sx(coef_m[i]));
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((samp_q.size() != 0 || load_q.size() != 0 || busy ||
                fifo_level != 0) && t < 200) begin
            cyc_start();
            t++;
        end
        repeat (3) cyc_start();
        chk("drain_in_time", t < 200, 1);
        chk("drain_level", fifo_level, 0);
    endtask

    initial begin
        bit ok;
        int idx;
        int t;
        for (int i = 0; i < 4; i++) coef_m[i] = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x_n", x_n, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_set", set_c, 0);
        chk("rst_busy", busy, 1);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_level", fifo_level, 0);

        // setup window with 0x11 offered from release
        cyc_start();
        rst_n = 1'b1;
        push(8'h11, ok);
        for (int i = 0; i < 4; i++) begin
            cyc_start();
            if (i < 2) push(8'h11, ok);
            @(negedge clk);
            chk("setup_quiet", {x_n, tvalid, set_c}, 0);
        end
        t = 0;
        while (!tvalid && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("first_stream_beat", tvalid, 1);
        wait_idle();

        // coefficient load sequence and commit latency
        cyc_start(); write(0, 6'h05);
        cyc_start(); write(1, 6'h3E);
        cyc_start(); write(2, 6'h01);
        cyc_start(); write(3, 6'h15);
        cyc_start(); commit();
        cyc_start();
        @(negedge clk);
        chk("commit_n0_set", set_c, 0);
        chk("commit_busy", busy, 1);
        cyc_start();
        @(negedge clk);
        chk("commit_n1_set", set_c, 0);
        for (int k = 0; k < NT; k++) begin
            cyc_start();
            if (k == 0) write(0, 6'h07);
            @(negedge clk);
            chk("load_set", set_c, 1);
            chk("load_x_n", x_n, (k == 0) ? 8'h01 : (k == 1) ? 8'hFE : 8'h05);
        end
        cyc_start();
        @(negedge clk);
        chk("gap_strobes", {tvalid, set_c}, 0);
        chk("gap_x_n", x_n, 0);
        wait_idle();

        // ten samples offered while stalled by two loads
        idx = 0;
        for (int i = 0; i <= 10; i++) begin
            cyc_start();
            if (i == 0 || i == 2) commit();
            if (i >= 1) begin
                push(8'hA0 + 8'(idx), ok);
                if (ok) idx++;
            end
        end
        cyc_start();
        chk("stall_accepted", idx, 8);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_level", fifo_level, 8);
        t = 0;
        while (idx < 10 && t < 50) begin
            push(8'hA0 + 8'(idx), ok);
            if (ok) idx++;
            cyc_start();
            t++;
        end
        chk("stall_rest_accepted", idx, 10);
        wait_idle();

        // commit mid-stream
        for (int i = 0; i < 6; i++) begin
            cyc_start();
            push(8'h30 + 8'(i), ok);
            if (i == 3) commit();
        end
        wait_idle();

        // reset during the second load cycle
        cyc_start();
        commit();
        push(8'h55, ok);
        cyc_start();
        push(8'h56, ok);
        t = 0;
        while (!set_c && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("reset_load_started", set_c, 1);
        cyc_start();
        rst_n = 1'b0;
        #1;
        chk("arst_x_n", x_n, 0);
        chk("arst_strobes", {tvalid, set_c}, 0);
        chk("arst_busy", busy, 1);
        chk("arst_level", fifo_level, 0);
        load_q.delete();
        samp_q.delete();
        for (int i = 0; i < 4; i++) coef_m[i] = '0;
        repeat (2) cyc_start();
        rst_n = 1'b1;
        repeat (20) cyc_start();
        commit();
        wait_idle();

        // empty FIFO behaviour after a drain
        cyc_start();
        push(8'h7E, ok);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef FIR_DRV_ZEROFILL_EN
            chk("zf_tvalid", tvalid, 1);
            chk("zf_x_n", x_n, 0);
`else
            chk("empty_tvalid", tvalid, 0);
            chk("empty_busy", busy, 0);
`endif
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc_start();
            if ($urandom_range(2) != 0) push(8'($urandom), ok);
            if (!busy && $urandom_range(7) == 0)
                write(int'($urandom_range(3)), 6'($urandom));
            if (!busy && $urandom_range(29) == 0) commit();
        end
        wait_idle();
        chk("final_samples_left", samp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_stream_driver.md
# fir_stream_driver

Upstream initiator for the FIR filter core: accepts samples from a host over a valid/ready port, holds a shadow coefficient bank, and drives the filter's `x_n`, `s_axis_fir_tvalid` and `s_set_coeffs` inputs with the exact sequencing the core expects.
- Covers the post-reset setup window, coefficient shift-in order, the config-to-idle gap, and the sample stream.
- Sits between the chip I/O and the FIR instance, in the same clock domain as the core.

## Interface
- `X_N_SIZE`, 8: sample width; equals the filter's sample width.
- `TAP_SIZE`, 6: coefficient width.
- `NBR_OF_TAPS`, 3: number of coefficients; 2..8.
- `FIFO_DEPTH`, 8: sample FIFO entries; power of two.
- `SETUP_CYCLES`, 4: cycles after reset release before any drive.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in X_N_SIZE: host sample.
- `in_valid` in 1: host sample valid.
- `in_ready` out 1: `!fifo_full`; reset 1.
- `cfg_we` in 1: coefficient shadow write strobe.
- `cfg_addr` in clog2(NBR_OF_TAPS): coefficient index.
- `cfg_data` in TAP_SIZE: coefficient value.
- `cfg_commit` in 1: one-cycle request to load the shadow bank into the filter.
- `x_n` out X_N_SIZE: to filter; reset 0.
- `s_axis_fir_tvalid` out 1: to filter; reset 0.
- `s_set_coeffs` out 1: to filter; reset 0.
- `busy` out 1: high in SETUP, LOAD or GAP, or while a commit is pending; reset 1.
- `fifo_level` out clog2(FIFO_DEPTH)+1: occupancy; reset 0.

## Operation
- Shadow bank:
  - `cfg_we` writes `coef[cfg_addr]` at the edge.
  - Out-of-range addresses are ignored.
  - Reset value is all zeros.
- Sample FIFO:
  - A push occurs on `in_valid && in_ready`.
  - Pushes and pops are independent and can happen in the same cycle.
  - The push is accepted when the FIFO is non-full.
  - Pointers wrap modulo FIFO_DEPTH.
- `commit_pend`:
  - Set by `cfg_commit`.
  - Cleared on entry to LOAD.
  - A commit arriving while LOAD or GAP is active sets `commit_pend` again, so the load sequence runs again.
- FSM states and transitions:
  - SETUP: all drive outputs 0; count SETUP_CYCLES cycles, then go to IDLE.
  - IDLE: if `commit_pend`, go to LOAD; else if FIFO non-empty, go to STREAM.
  - LOAD:
    - Lasts NBR_OF_TAPS cycles with `s_set_coeffs=1` and `tvalid=0`.
    - `x_n` is the sign-extended `coef[NBR_OF_TAPS-1-k]` in cycle k.
    - This order leaves `coef[0]` in filter tap 0.
    - Then go to GAP.
  - GAP: one cycle with both strobes 0 and `x_n=0`, so the filter returns to its idle state; then go to IDLE.
  - STREAM:
    - Each cycle the FIFO is non-empty: pop the head, drive `x_n` = head, `tvalid=1`.
    - FIFO empty: `tvalid=0`, `x_n=0`, stay in STREAM.
    - `commit_pend` after the current cycle's pop: go to LOAD next cycle.
    - FIFO empty and no pending commit for one cycle: go to IDLE.
- Commit has priority over samples. Samples remaining in the FIFO are preserved and resume after GAP.
- `cfg_we` during LOAD:
  - Writes the shadow bank.
  - Does not affect the sequence in flight, which uses a snapshot taken on entry to LOAD.

## Timing
- Outputs `x_n`, `tvalid` and `s_set_coeffs` are registered; they change only on a rising edge.
- The filter samples on the falling edge, giving half-cycle setup.
- Sample latency: when the FIFO is empty and the FSM is in STREAM, a sample accepted at edge N appears on `x_n` with `tvalid` at edge N+1. From IDLE the latency is N+2 because of the IDLE→STREAM step.
- Commit latency: `cfg_commit` at edge N in IDLE gives `s_set_coeffs` high from edge N+2 for NBR_OF_TAPS cycles, followed by one GAP cycle.
- `s_set_coeffs` and `s_axis_fir_tvalid` are never high in the same cycle.
- A reset assertion mid-operation:
  - Clears the FIFO, the shadow bank and `commit_pend` immediately.
  - Forces SETUP; outputs go to their reset values asynchronously.
  - Any partial load into the filter is abandoned.

## Configuration
- `FIR_DRV_ZEROFILL_EN`:
  - Defined: in STREAM with the FIFO empty, drive `tvalid=1` with `x_n=0`, so the filter stays active and flushes with zeros. Leave STREAM only on a commit.
  - Undefined: `tvalid=0` on an empty FIFO, with the STREAM→IDLE transition as described above.

## Test plan
- Reset release, `in_valid` held with 0x11 → no drive-output activity for 4 cycles; afterward 0x11 is streamed with `tvalid=1`.
- Write coef {0:0x05, 1:0x3E, 2:0x01}, commit in IDLE → `s_set_coeffs` high for 3 cycles with `x_n`=0x01, 0xFE, 0x05, then one GAP cycle with both strobes low.
- Push 10 samples back-to-back while stalled in LOAD → `in_ready` drops after 8 accepted; all 8 are streamed in order after GAP; `fifo_level` returns to 0.
- Commit mid-stream with 3 samples queued → the stream pauses, the 3-cycle load and GAP follow, then the 3 samples resume and none are lost.
- `rst_n` low during the second LOAD cycle → outputs go to 0 immediately; SETUP restarts; no `s_set_coeffs` is seen until a new commit.
- With `FIR_DRV_ZEROFILL_EN` defined, FIFO drains → `tvalid` stays 1 with `x_n`=0 until a commit.
